// File: rtl/difftest_commit_sched.sv
// Commit scheduler: buffers core commit records in a FIFO and hands them to the difftest checker.
// Optional watchdog (idle counter + sticky hang) is built when DIFFTEST_WATCHDOG_EN is defined.
module difftest_commit_sched #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            cmt_valid_i,
    output logic            cmt_ready_o,
    input  logic [XLEN-1:0] cmt_pc_i,
    input  logic [31:0]     cmt_inst_i,
    input  logic            cmt_wen_i,
    input  logic [4:0]      cmt_waddr_i,
    input  logic [XLEN-1:0] cmt_wdata_i,
    input  logic            cmt_skip_i,
    input  logic            cmt_halt_i,
    output logic            chk_valid_o,
    input  logic            chk_ready_i,
    output logic [XLEN-1:0] chk_pc_o,
    output logic [31:0]     chk_inst_o,
    output logic            chk_wen_o,
    output logic [4:0]      chk_waddr_o,
    output logic [XLEN-1:0] chk_wdata_o,
    output logic            chk_skip_o,
    output logic            chk_halt_o,
    output logic [63:0]     commit_cnt_o,
    output logic            done_o,
    output logic            hang_o
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            wen;
        logic [4:0]      waddr;
        logic [XLEN-1:0] wdata;
        logic            skip;
        logic            halt;
    } rec_t;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    rec_t        mem_q [DEPTH];
    rec_t        wr_rec, head;
    logic [AW:0] wptr_q, rptr_q, occ;
    logic [63:0] cnt_q;
    logic        full, empty, push, pop;

    assign occ   = wptr_q - rptr_q;
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    assign cmt_ready_o = !full && (state_q == RUN);
    assign chk_valid_o = !empty;
    assign push        = cmt_valid_i && cmt_ready_o;
    assign pop         = chk_valid_o && chk_ready_i;

    // x0 writes are dropped here so the checker never sees a write to the zero register
    always_comb begin
        wr_rec       = '0;
        wr_rec.pc    = cmt_pc_i;
        wr_rec.inst  = cmt_inst_i;
        wr_rec.wen   = cmt_wen_i && (cmt_waddr_i != 5'd0);
        wr_rec.waddr = cmt_waddr_i;
        wr_rec.wdata = cmt_wdata_i;
        wr_rec.skip  = cmt_skip_i;
        wr_rec.halt  = cmt_halt_i;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
        end else begin
            if (push) begin
                mem_q[wptr_q[AW-1:0]] <= wr_rec;
                wptr_q <= wptr_q + 1'b1;
                cnt_q  <= cnt_q + 64'd1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            state_q <= state_d;
        end
    end

    // No pushes happen in DRAIN, so popping the only entry empties the FIFO
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (push && cmt_halt_i) state_d = DRAIN;
            DRAIN:   if (pop && occ == (AW+1)'(1)) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    assign head         = mem_q[rptr_q[AW-1:0]];
    assign chk_pc_o     = head.pc;
    assign chk_inst_o   = head.inst;
    assign chk_wen_o    = head.wen;
    assign chk_waddr_o  = head.waddr;
    assign chk_wdata_o  = head.wdata;
    assign chk_skip_o   = head.skip;
    assign chk_halt_o   = head.halt;
    assign commit_cnt_o = cnt_q;
    assign done_o       = (state_q == DONE);

`ifdef DIFFTEST_WATCHDOG_EN
    localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LIM = IW'(TIMEOUT - 1);

    logic [IW-1:0] idle_q, idle_d;
    logic          hang_q;

    always_comb begin
        idle_d = idle_q;
        if (push)                                idle_d = '0;
        else if (state_q == RUN && idle_q != LIM) idle_d = idle_q + 1'b1;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            idle_q <= '0;
            hang_q <= 1'b0;
        end else begin
            idle_q <= idle_d;
            hang_q <= hang_q | (idle_d == LIM);
        end
    end

    assign hang_o = hang_q;
`else
    assign hang_o = 1'b0;
`endif

endmodule
